// File: rtl/result_display_driver.sv
// ---------------------------------------------------------------------------
// result_display_driver
//
// Reads the final result (register 15) of the register file. On a load
// strobe it captures the signed 32-bit word and converts its magnitude to
// decimal with a sequential double-dabble engine, one shift per clock. The
// converted value drives a time-multiplexed, active-low seven-segment
// display, along with sign and overflow indicators. Nothing in this block
// writes back into the datapath.
//
// Parameters
//   NUM_DIGITS   number of physical digits (1..10)
//   REFRESH_DIV  clk cycles each digit stays lit (>= 2)
//
// Ports
//   clk     in   1           system clock, all state on rising edge
//   rst_n   in   1           asynchronous active-low reset
//   result  in   32          signed result word from register-file port 15
//   load    in   1           capture request, sampled only while idle
//   busy    out  1           conversion in progress
//   seg     out  7           active-low segments, seg[6:0] = g,f,e,d,c,b,a
//   an      out  NUM_DIGITS  active-low one-hot digit enables
//   neg     out  1           displayed value is negative
//   ovf     out  1           magnitude does not fit in NUM_DIGITS digits
// ---------------------------------------------------------------------------
module result_display_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           result,
    input  logic                  load,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  neg,
    output logic                  ovf
);

    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W      = $clog2(REFRESH_DIV);
    localparam int BCD_DIGITS = 10;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LATCH
    } state_t;

    state_t                 state;
    logic [31:0]            mag;
    logic                   sign;
    logic [39:0]            bcd;
    logic [4:0]             shift_cnt;
    logic [39:0]            disp_bcd;

    logic [39:0]            bcd_adj;
    logic                   ovf_calc;

    logic [39:0]            disp_view;
    logic                   ovf_view;
    logic [CNT_W-1:0]       refresh_cnt;
    logic [CNT_W-1:0]       refresh_next;
    logic [IDX_W-1:0]       scan_idx;
    logic [IDX_W-1:0]       scan_next;
    logic [3:0]             digit_val;
    logic                   higher_nz;
    logic [6:0]             seg_next;
    logic [NUM_DIGITS-1:0]  an_next;

    // Double-dabble correction: every BCD nibble of 5 or more gets 3 added
    // so the following left shift carries correctly into the next decade.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Overflow means some decade beyond the physical digits is nonzero.
    always_comb begin
        ovf_calc = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if ((i >= NUM_DIGITS) && (bcd[4*i +: 4] != 4'd0)) begin
                ovf_calc = 1'b1;
            end
        end
    end

    // Conversion FSM. The magnitude is captured unsigned, so 0x80000000
    // becomes 2147483648. After 32 shifts the BCD result is complete and the
    // LATCH state publishes it to the display registers in a single step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mag       <= '0;
            sign      <= 1'b0;
            bcd       <= '0;
            shift_cnt <= '0;
            disp_bcd  <= '0;
            busy      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        mag       <= result[31] ? (~result + 32'd1) : result;
                        sign      <= result[31];
                        bcd       <= '0;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    {bcd, mag} <= {bcd_adj[38:0], mag, 1'b0};
                    shift_cnt  <= shift_cnt + 5'd1;
                    if (shift_cnt == 5'd31) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    disp_bcd <= bcd;
                    neg      <= sign && (bcd != 40'd0);
                    ovf      <= ovf_calc;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The segment pattern is decoded from next-cycle values so that seg and
    // an are registered on the same edge as the scan index and the display
    // data. A freshly latched result therefore appears on the same edge that
    // updates neg and ovf, with no skew between enables and segments.
    always_comb begin
        disp_view = (state == LATCH) ? bcd : disp_bcd;
        ovf_view  = (state == LATCH) ? ovf_calc : ovf;

        if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_next = '0;
            if (scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
                scan_next = '0;
            end else begin
                scan_next = scan_idx + 1'b1;
            end
        end else begin
            refresh_next = refresh_cnt + 1'b1;
            scan_next    = scan_idx;
        end

        digit_val = 4'd0;
        higher_nz = 1'b0;
        an_next   = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == scan_next) begin
                digit_val  = disp_view[4*j +: 4];
                an_next[j] = 1'b0;
            end
            if ((IDX_W'(j) >= scan_next) && (disp_view[4*j +: 4] != 4'd0)) begin
                higher_nz = 1'b1;
            end
        end

        if (ovf_view) begin
            seg_next = SEG_DASH;
        end else if ((scan_next != '0) && !higher_nz) begin
            seg_next = SEG_BLANK;
        end else begin
            case (digit_val)
                4'd0:    seg_next = 7'b1000000;
                4'd1:    seg_next = 7'b1111001;
                4'd2:    seg_next = 7'b0100100;
                4'd3:    seg_next = 7'b0110000;
                4'd4:    seg_next = 7'b0011001;
                4'd5:    seg_next = 7'b0010010;
                4'd6:    seg_next = 7'b0000010;
                4'd7:    seg_next = 7'b1111000;
                4'd8:    seg_next = 7'b0000000;
                4'd9:    seg_next = 7'b0010000;
                default: seg_next = SEG_DASH;
            endcase
        end
    end

    // Refresh counter, scan index and the registered display outputs. This
    // runs continuously, independent of the conversion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            seg         <= SEG_ZERO;
            an          <= ~NUM_DIGITS'(1);
        end else begin
            refresh_cnt <= refresh_next;
            scan_idx    <= scan_next;
            seg         <= seg_next;
            an          <= an_next;
        end
    end

endmodule
